block_streamer: RTL and testbench

BLOCK_STREAMER -- requirements
Module: block_streamer

---
 rtl/block_streamer.sv | 134 +++++++++++++
 tb/tb_block_streamer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/block_streamer.sv
// block_streamer: collects one ROWS-row block of reference/filter row pairs, then
// replays it as a gapless ROWS-cycle burst followed by a single idle (done) cycle.
module block_streamer #(
  parameter int ROWS  = 8,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*PIX_W-1:0] in_ref_row,
  input  logic [8*PIX_W-1:0] in_filt_row,
  output logic [8*PIX_W-1:0] ref_pix,
  output logic [8*PIX_W-1:0] filter_pix,
  output logic               input_ready,
  output logic               block_done,
  output logic [7:0]         blocks_sent,
  output logic [1:0]         state_o
);
  localparam int W     = 8 * PIX_W;
  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [W-1:0]     ref_q, ref_d;
  logic [W-1:0]     filt_q, filt_d;
  logic             input_ready_q, input_ready_d;
  logic             block_done_q, block_done_d;
  logic [7:0]       blocks_sent_q, blocks_sent_d;
  logic             wr_en;

  logic [W-1:0] ref_mem  [ROWS];
  logic [W-1:0] filt_mem [ROWS];

  // Handshake: a row pair transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in FILL and never while reset is asserted, and the
  // downstream side has no back-pressure (input_ready just marks a valid row).
  assign in_ready = (state_q == FILL) && !reset;

  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    ref_d         = ref_q;
    filt_d        = filt_q;
    input_ready_d = 1'b0;
    block_done_d  = 1'b0;
    blocks_sent_d = blocks_sent_q;
    wr_en         = 1'b0;
    case (state_q)
      FILL: begin
        if (in_valid && in_ready) begin
          wr_en = 1'b1;
          if (wr_cnt_q == LAST) begin
            wr_cnt_d      = ZERO;
            rd_cnt_d      = ZERO;
            state_d       = STREAM;
            input_ready_d = 1'b1;
            // With ROWS == 1 row 0 is being written this very edge, so bypass the buffer.
            ref_d  = (wr_cnt_q == ZERO) ? in_ref_row  : ref_mem[ZERO];
            filt_d = (wr_cnt_q == ZERO) ? in_filt_row : filt_mem[ZERO];
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      STREAM: begin
        if (rd_cnt_q == LAST) begin
          state_d       = GAP;
          block_done_d  = 1'b1;
          blocks_sent_d = blocks_sent_q + 8'd1;
        end else begin
          rd_cnt_d      = rd_cnt_q + 1'b1;
          ref_d         = ref_mem[rd_cnt_d];
          filt_d        = filt_mem[rd_cnt_d];
          input_ready_d = 1'b1;
        end
      end
      GAP: begin
        state_d = FILL;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FILL;
      wr_cnt_q      <= ZERO;
      rd_cnt_q      <= ZERO;
      ref_q         <= '0;
      filt_q        <= '0;
      input_ready_q <= 1'b0;
      block_done_q  <= 1'b0;
      blocks_sent_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      ref_q         <= ref_d;
      filt_q        <= filt_d;
      input_ready_q <= input_ready_d;
      block_done_q  <= block_done_d;
      blocks_sent_q <= blocks_sent_d;
    end
  end

  // Row storage is not reset; a row is only ever read after this block rewrote it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ref_mem[wr_cnt_q]  <= in_ref_row;
      filt_mem[wr_cnt_q] <= in_filt_row;
    end
  end

  assign ref_pix     = ref_q;
  assign filter_pix  = filt_q;
  assign input_ready = input_ready_q;
  assign block_done  = block_done_q;
  assign blocks_sent = blocks_sent_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_block_streamer.sv
// tb_block_streamer: randomized fills checked by a block-level reference model
// (queue of accepted rows, busy-cycle countdown) and a negedge scoreboard monitor.
module tb_block_streamer;
  localparam int ROWS   = 8;
  localparam int PIX_W  = 8;
  localparam int W      = 8 * PIX_W;
  localparam int CW     = 2 * W;
  localparam int PERIOD = 2 * ROWS + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_ref_row = '0;
  logic [W-1:0] in_filt_row = '0;
  logic [W-1:0] ref_pix;
  logic [W-1:0] filter_pix;
  logic         input_ready;
  logic         block_done;
  logic [7:0]   blocks_sent;
  logic [1:0]   state_o;

  block_streamer #(.ROWS(ROWS), .PIX_W(PIX_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ref_row  (in_ref_row),
    .in_filt_row (in_filt_row),
    .ref_pix     (ref_pix),
    .filter_pix  (filter_pix),
    .input_ready (input_ready),
    .block_done  (block_done),
    .blocks_sent (blocks_sent),
    .state_o     (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] pend_q[$];
  logic [CW-1:0] last_pair = '0;
  logic [7:0]    sent_m = '0;
  int            busy = 0;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_fail = 0;
  bit            period_chk = 1'b0;
  int            last_done = -1;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp_v);
    end
  endtask

  // Block-level model: a block is ROWS accepted pairs; once complete the block
  // is unavailable for ROWS stream cycles plus one gap cycle.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        pend_q.delete();
        exp_q.delete();
        busy   = 0;
        sent_m = '0;
      end else if (busy > 0) begin
        if (busy == 2) sent_m++;
        busy--;
      end else if (in_valid) begin
        pend_q.push_back({in_ref_row, in_filt_row});
        if (pend_q.size() == ROWS) begin
          foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
          pend_q.delete();
          busy = ROWS + 1;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [CW-1:0] exp_v;
    forever begin
      @(negedge clk);
      check("in_ready", CW'(in_ready), CW'(!reset && busy == 0));
      check("input_ready", CW'(input_ready), CW'(busy > 1));
      check("block_done", CW'(block_done), CW'(busy == 1));
      check("blocks_sent", CW'(blocks_sent), CW'(sent_m));
      check("state_legal", CW'(state_o != 2'd3), CW'(1'b1));
      if (input_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL stream_row @cycle %0d: got row %h with no expected row queued", cyc, {ref_pix, filter_pix});
        end else begin
          exp_v = exp_q.pop_front();
          check("stream_row", {ref_pix, filter_pix}, exp_v);
          last_pair = exp_v;
        end
      end else begin
        check("hold_row", {ref_pix, filter_pix}, last_pair);
      end
      if (block_done && period_chk) begin
        if (last_done >= 0) check("block_period", CW'(cyc - last_done), CW'(PERIOD));
        last_done = cyc;
      end
      if (reset) last_pair = '0;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*PIX_W +: PIX_W] = PIX_W'($urandom);
    return r;
  endfunction

  // Holds in_valid high; junk data is presented while the block is busy so that
  // only the pair offered on an accepting cycle may enter the block.
  task automatic send_row(input logic [W-1:0] r, input logic [W-1:0] f);
    bit acc;
    int waited;
    acc    = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    while (!acc && waited < 64) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        in_ref_row  = r;
        in_filt_row = f;
      end else begin
        in_ref_row  = rand_row();
        in_filt_row = rand_row();
      end
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout @cycle %0d: got in_ready=0 for %0d cycles expected 1", cyc, waited);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid    = 1'b0;
      in_ref_row  = rand_row();
      in_filt_row = rand_row();
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: byte pattern k / k+0x10, back-to-back; 1: random back-to-back; 2: random, valid toggling
  task automatic fill_block(input int mode);
    for (int k = 0; k < ROWS; k++) begin
      if (mode == 2 && k > 0) idle(1);
      if (mode == 0) send_row({8{PIX_W'(k)}}, {8{PIX_W'(k + 16)}});
      else           send_row(rand_row(), rand_row());
    end
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset(3);

    // Patterned block, then drain.
    fill_block(0);
    idle(ROWS + 2);
    check("sent_after_first", CW'(blocks_sent), CW'(8'd1));

    // Toggling in_valid during fill.
    fill_block(2);
    idle(ROWS + 2);

    // in_valid held high with changing data across STREAM/GAP.
    repeat (3) fill_block(1);
    idle(ROWS + 2);

    // Reset while stream row 3 is presented.
    do_reset(1);
    fill_block(1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midstream_reset_input_ready", CW'(input_ready), CW'(1'b0));
    check("midstream_reset_sent", CW'(blocks_sent), CW'(8'd0));
    idle(2);
    fill_block(1);
    idle(ROWS + 2);
    check("sent_after_reset_block", CW'(blocks_sent), CW'(8'd1));

    // 256 back-to-back blocks: counter wrap and block period.
    do_reset(1);
    last_done  = -1;
    period_chk = 1'b1;
    repeat (256) fill_block(1);
    idle(ROWS + 2);
    period_chk = 1'b0;
    check("sent_wrap", CW'(blocks_sent), CW'(8'd0));

    // Random idle gaps between rows and blocks.
    repeat (6) begin
      for (int k = 0; k < ROWS; k++) begin
        idle($urandom_range(0, 2));
        send_row(rand_row(), rand_row());
      end
      idle($urandom_range(0, 3));
    end
    idle(ROWS + 2);
    check("scoreboard_empty", CW'(exp_q.size()), CW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog @cycle %0d: got no end of test expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
